adc_moving_average: RTL and testbench
=====================================

Name: adc_moving_average

Overview:
- Post-processing stage directly downstream of the PWM ADC top level.
- Consumes each raw 16-bit conversion result and its one-cycle ready strobe.
- Produces a boxcar (moving-average) filtered sample over the last 2^LOG2_N conversions, plus running min/max peak-hold values.
- Feeds the display/readout logic with a stable, noise-reduced value.

Parameters:
- DATA_WIDTH, 16, width of raw ADC samples and of all data outputs.
- LOG2_N, 4, log2 of window length; window N = 2^LOG2_N (default 16). Legal range 1..6.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  one-cycle strobe; in_data is a new sample (driven by ADC data_ready).
- in_data  input  DATA_WIDTH  raw ADC sample (driven by ADC adc_out).
- clear  input  1  synchronous flush of window, sum and peak-hold registers.
- avg_valid  output  1  one-cycle pulse; avg_out/min_out/max_out updated.
- avg_out  output  DATA_WIDTH  moving average of the last N samples.
- min_out  output  DATA_WIDTH  smallest sample accepted since reset/clear.
- max_out  output  DATA_WIDTH  largest sample accepted since reset/clear.
- filled  output  1  high once N samples are accepted since reset/clear.

Behaviour:
Reset (reset low, asynchronous):
- All outputs are 0, except min_out = all ones.
- Sample buffer, running sum, write pointer and fill counter are cleared to 0.
- Takes effect immediately, including mid-stream. The first in_valid after release is treated as sample #1.

Storage:
- N-entry register buffer, indexed by wr_ptr of width LOG2_N.
- Running sum of width DATA_WIDTH+LOG2_N; it never overflows.
- fill_cnt of width LOG2_N+1, saturating at N.

Accepted sample (in_valid=1, clear=0), all updated in the same cycle:
- sum <= sum + in_data - buf[wr_ptr]
- buf[wr_ptr] <= in_data
- wr_ptr <= wr_ptr+1, wrapping from N-1 to 0.
- fill_cnt <= min(fill_cnt+1, N)
- min/max register <= min/max of the current value and in_data (unsigned compare).

Output timing:
- Latency is 1 cycle: on the clock edge after an accepted sample, avg_out = new_sum >> LOG2_N (truncation, no rounding) and avg_valid is high for exactly one cycle.
- avg_out, min_out and max_out hold their values between pulses.
- Throughput is 1 sample/cycle. Back-to-back in_valid gives back-to-back avg_valid pulses, and no sample is dropped.

Warm-up:
- Empty buffer slots read as 0, so before `filled` the average ramps: sum of k samples / N.
- `filled` rises in the same cycle as the avg_valid pulse for sample #N and stays high until reset or clear.

clear=1 (synchronous):
- Next edge zeroes buf, sum, wr_ptr, fill_cnt and filled.
- max_out <= 0, min_out <= all ones, avg_out <= 0.
- No avg_valid pulse.
- Simultaneous clear and in_valid: clear wins and the sample is discarded.

Structure:
- No FSM beyond the fill counter.
- All logic is a single clocked domain; no combinational path from inputs to outputs.

Test Plan:
1. Warm-up: after reset, 1 sample of 0x0100 -> next cycle avg_valid=1, avg_out=0x0010, filled=0, min_out=max_out=0x0100.
2. Fill: 16 samples of 0x0100 (in_valid every 5 cycles) -> 16th pulse avg_out=0x0100 and filled rises in the same cycle; exactly 16 avg_valid pulses.
3. Wrap/sliding: continue from (2) with 8 samples of 0x0200 -> avg_out=0x0180, wr_ptr wrapped, min_out=0x0100, max_out=0x0200.
4. Full-scale/overflow: 16 back-to-back samples of 0xFFFF (in_valid high 16 consecutive cycles) -> 16 consecutive avg_valid pulses; final avg_out=0xFFFF, internal sum=0xFFFF0, no wrap.
5. Clear priority: assert clear together with in_valid (in_data=0x1234) after filled=1 -> no avg_valid; avg_out=0, filled=0, min_out=0xFFFF, max_out=0. Next sample 0x0040 -> avg_out=0x0004.
6. Async reset mid-stream: drop reset between two in_valid strobes -> all outputs immediately reset values (min_out=0xFFFF). After release, sample 0x0800 -> avg_out=0x0080.

Source files
------------

// File: rtl/adc_moving_average.sv
// Boxcar moving-average filter over the last 2^LOG2_N ADC conversions,
// with running min/max peak-hold. Every output is registered.
module adc_moving_average #(
    parameter int DATA_WIDTH = 16,
    parameter int LOG2_N     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  clear,
    output logic                  avg_valid,
    output logic [DATA_WIDTH-1:0] avg_out,
    output logic [DATA_WIDTH-1:0] min_out,
    output logic [DATA_WIDTH-1:0] max_out,
    output logic                  filled
);

    localparam int N     = 1 << LOG2_N;
    localparam int SUM_W = DATA_WIDTH + LOG2_N;
    localparam logic [LOG2_N:0] FULL = (LOG2_N + 1)'(N);

    logic [DATA_WIDTH-1:0] sample_buf [N];
    logic [SUM_W-1:0]      sum;
    logic [SUM_W-1:0]      sum_next;
    logic [LOG2_N-1:0]     wr_ptr;
    logic [LOG2_N:0]       fill_cnt;
    logic [LOG2_N:0]       fill_next;
    logic                  accept;

    // Unfilled slots hold 0, so subtracting the oldest entry is always correct.
    always_comb begin
        accept    = in_valid && !clear;
        sum_next  = sum + SUM_W'(in_data) - SUM_W'(sample_buf[wr_ptr]);
        fill_next = (fill_cnt == FULL) ? fill_cnt : fill_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) sample_buf[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < N; i++) sample_buf[i] <= '0;
        end else if (accept) begin
            sample_buf[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum      <= '0;
            wr_ptr   <= '0;
            fill_cnt <= '0;
        end else if (clear) begin
            sum      <= '0;
            wr_ptr   <= '0;
            fill_cnt <= '0;
        end else if (accept) begin
            sum      <= sum_next;
            wr_ptr   <= wr_ptr + 1'b1;
            fill_cnt <= fill_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            avg_valid <= 1'b0;
            avg_out   <= '0;
            min_out   <= '1;
            max_out   <= '0;
            filled    <= 1'b0;
        end else if (clear) begin
            avg_valid <= 1'b0;
            avg_out   <= '0;
            min_out   <= '1;
            max_out   <= '0;
            filled    <= 1'b0;
        end else if (accept) begin
            avg_valid <= 1'b1;
            avg_out   <= sum_next[SUM_W-1:LOG2_N];
            min_out   <= (in_data < min_out) ? in_data : min_out;
            max_out   <= (in_data > max_out) ? in_data : max_out;
            filled    <= (fill_next == FULL);
        end else begin
            avg_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_moving_average.sv
// Self-checking bench for adc_moving_average: directed scenarios followed by
// randomized traffic, compared against a sliding-window queue model.
module tb_adc_moving_average;

    localparam int DW = 16;
    localparam int L  = 4;
    localparam int N  = 1 << L;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          clear = 1'b0;
    logic          avg_valid;
    logic [DW-1:0] avg_out;
    logic [DW-1:0] min_out;
    logic [DW-1:0] max_out;
    logic          filled;

    adc_moving_average #(.DATA_WIDTH(DW), .LOG2_N(L)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_data(in_data),
        .clear(clear),
        .avg_valid(avg_valid),
        .avg_out(avg_out),
        .min_out(min_out),
        .max_out(max_out),
        .filled(filled)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    int unsigned   win[$];
    int            accepted;
    logic [DW-1:0] exp_avg;
    logic [DW-1:0] exp_min;
    logic [DW-1:0] exp_max;
    logic          exp_filled;
    logic          exp_valid;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic void modelReset();
        win.delete();
        accepted   = 0;
        exp_avg    = '0;
        exp_min    = '1;
        exp_max    = '0;
        exp_filled = 1'b0;
        exp_valid  = 1'b0;
    endfunction

    function automatic int unsigned windowSum();
        int unsigned s = 0;
        foreach (win[i]) s += win[i];
        return s;
    endfunction

    task automatic checkAll(input string phase);
        checkOutput({phase, ".avg_valid"}, 32'(avg_valid), 32'(exp_valid));
        checkOutput({phase, ".avg_out"},   32'(avg_out),   32'(exp_avg));
        checkOutput({phase, ".min_out"},   32'(min_out),   32'(exp_min));
        checkOutput({phase, ".max_out"},   32'(max_out),   32'(exp_max));
        checkOutput({phase, ".filled"},    32'(filled),    32'(exp_filled));
    endtask

    // One clock of stimulus; the model advances and outputs are checked 1ns after the edge.
    task automatic applyStimulus(input string phase, input bit v, input logic [DW-1:0] d, input bit c);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        clear    = c;
        @(posedge clk);
        #1;
        if (c) begin
            modelReset();
        end else if (v) begin
            win.push_back(int'(d));
            if (win.size() > N) void'(win.pop_front());
            accepted++;
            exp_avg    = DW'(windowSum() / N);
            exp_min    = (d < exp_min) ? d : exp_min;
            exp_max    = (d > exp_max) ? d : exp_max;
            exp_filled = (accepted >= N);
            exp_valid  = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
        if (avg_valid) pulses++;
        checkAll(phase);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        clear = 1'b0;
        #1;
        modelReset();
        checkAll("reset");
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        modelReset();
        #12;
        checkAll("por");
        reset = 1'b1;

        // Warm-up: a single sample ramps the average to 1/N of its value.
        applyStimulus("warm", 1'b1, 16'h0100, 1'b0);
        checkOutput("warm.avg_const", 32'(avg_out), 32'h0010);
        applyStimulus("warm", 1'b0, 16'h0000, 1'b0);

        // Fill with sparse strobes and count pulses.
        doReset();
        pulses = 0;
        for (int i = 0; i < N; i++) begin
            applyStimulus("fill", 1'b1, 16'h0100, 1'b0);
            if (i == N - 2) checkOutput("fill.not_yet", 32'(filled), 32'h0);
            if (i == N - 1) begin
                checkOutput("fill.avg_const", 32'(avg_out), 32'h0100);
                checkOutput("fill.filled_const", 32'(filled), 32'h1);
            end
            for (int k = 0; k < 4; k++) applyStimulus("fill", 1'b0, 16'h0000, 1'b0);
        end
        checkOutput("fill.pulses", 32'(pulses), 32'(N));

        // Sliding window across the wrap point.
        for (int i = 0; i < 8; i++) applyStimulus("slide", 1'b1, 16'h0200, 1'b0);
        checkOutput("slide.avg_const", 32'(avg_out), 32'h0180);
        checkOutput("slide.wr_ptr", 32'(dut.wr_ptr), 32'h8);
        checkOutput("slide.min_const", 32'(min_out), 32'h0100);
        checkOutput("slide.max_const", 32'(max_out), 32'h0200);

        // Full-scale back-to-back samples must not overflow the running sum.
        pulses = 0;
        for (int i = 0; i < N; i++) applyStimulus("full", 1'b1, 16'hFFFF, 1'b0);
        checkOutput("full.pulses", 32'(pulses), 32'(N));
        checkOutput("full.avg_const", 32'(avg_out), 32'hFFFF);
        checkOutput("full.sum", 32'(dut.sum), 32'h000FFFF0);
        applyStimulus("full", 1'b0, 16'h0000, 1'b0);

        // Clear beats a simultaneous sample.
        applyStimulus("clear", 1'b1, 16'h1234, 1'b1);
        checkOutput("clear.min_const", 32'(min_out), 32'hFFFF);
        applyStimulus("clear", 1'b1, 16'h0040, 1'b0);
        checkOutput("clear.avg_const", 32'(avg_out), 32'h0004);

        // Asynchronous reset between two strobes.
        applyStimulus("async", 1'b1, 16'h0300, 1'b0);
        applyStimulus("async", 1'b0, 16'h0000, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        modelReset();
        checkAll("async_rst");
        @(negedge clk);
        reset = 1'b1;
        applyStimulus("async", 1'b1, 16'h0800, 1'b0);
        checkOutput("async.avg_const", 32'(avg_out), 32'h0080);

        // Randomized traffic with occasional clears and extreme values.
        for (int i = 0; i < 600; i++) begin
            bit            v = ($urandom_range(0, 99) < 65);
            bit            c = ($urandom_range(0, 99) < 3);
            logic [DW-1:0] d;
            case ($urandom_range(0, 9))
                0:       d = 16'h0000;
                1:       d = 16'hFFFF;
                default: d = DW'($urandom);
            endcase
            applyStimulus("rand", v, d, c);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
